// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter with valid/ready backpressure, carry-out and zero flags.
// Define SHIFTER_PIPE_ROTATE_EN to enable ROL/ROR; otherwise those ops pass src_a through.
module shifter_pipe #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         src_a,
  input  logic [WIDTH-1:0]         src_b,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     carry,
  output logic                     zero
);

  localparam int SAW = $clog2(WIDTH);
`ifdef SHIFTER_PIPE_ROTATE_EN
  localparam int CW = 3;
`else
  localparam int CW = 2;
`endif
  localparam int C_LEFT  = 0;
  localparam int C_ARITH = 1;
  localparam int C_ROT   = 2;
  localparam logic [1:0] CK_NONE = 2'd0;
  localparam logic [1:0] CK_L    = 2'd1;
  localparam logic [1:0] CK_R    = 2'd2;

  // Barrel level k (k=0 is the largest amount) lives in this pipeline stage.
  function automatic int stage_of(input int k);
    return (k * LATENCY) / SAW;
  endfunction

  function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] v, input int n,
                                                 input logic [CW-1:0] ctl);
    logic [WIDTH-1:0] r;
`ifdef SHIFTER_PIPE_ROTATE_EN
    if (ctl[C_ROT])
      r = ctl[C_LEFT] ? ((v << n) | (v >> (WIDTH - n))) : ((v >> n) | (v << (WIDTH - n)));
    else
`endif
    if (ctl[C_LEFT])
      r = v << n;
    else if (ctl[C_ARITH])
      r = $unsigned($signed(v) >>> n);
    else
      r = v >> n;
    return r;
  endfunction

  logic             w_adv;
  logic             w_acc;
  logic [WIDTH-1:0] w_dec_val;
  logic [SAW-1:0]   w_dec_amt;
  logic [CW-1:0]    w_dec_ctl;
  logic             w_dec_carry;
  logic [1:0]       w_ck;
  logic [SAW:0]     w_lsh_b;
  logic [SAW:0]     w_lsh_mag;
  logic [WIDTH:0]   w_lext;
  logic [WIDTH:0]   w_rext;

  logic             r_rdy_en;
  logic             r_zero;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = r_rdy_en & w_adv;
  assign w_acc    = in_valid & in_ready;

  // Every op is reduced to value + amount + direction/fill; the carry is picked from the operand up front.
  always_comb begin
    w_dec_val   = src_a;
    w_dec_amt   = shamt;
    w_dec_ctl   = '0;
    w_ck        = CK_NONE;
    w_dec_carry = 1'b0;
    w_lsh_b     = src_b[SAW:0];
    w_lsh_mag   = w_lsh_b[SAW] ? (~w_lsh_b + (SAW+1)'(1)) : w_lsh_b;
    case (op)
      3'b000: begin w_dec_ctl[C_LEFT] = 1'b1; w_ck = CK_L; end
      3'b001: w_ck = CK_R;
      3'b010: begin w_dec_ctl[C_ARITH] = 1'b1; w_ck = CK_R; end
      3'b011: begin
        w_dec_val         = src_b;
        w_dec_amt         = SAW'(WIDTH / 2);
        w_dec_ctl[C_LEFT] = 1'b1;
      end
      3'b100: begin
        w_dec_amt         = w_lsh_mag[SAW] ? '1 : w_lsh_mag[SAW-1:0];
        w_dec_ctl[C_LEFT] = ~w_lsh_b[SAW];
        w_ck              = w_lsh_b[SAW] ? CK_R : CK_L;
      end
`ifdef SHIFTER_PIPE_ROTATE_EN
      3'b101: begin w_dec_ctl[C_LEFT] = 1'b1; w_dec_ctl[C_ROT] = 1'b1; w_ck = CK_L; end
      3'b110: begin w_dec_ctl[C_ROT] = 1'b1; w_ck = CK_R; end
`endif
      default: w_dec_amt = '0;
    endcase
    w_lext = {1'b0, src_a} << w_dec_amt;
    w_rext = {src_a, 1'b0} >> w_dec_amt;
    case (w_ck)
      CK_L:    w_dec_carry = w_lext[WIDTH];
      CK_R:    w_dec_carry = w_rext[0];
      default: w_dec_carry = 1'b0;
    endcase
  end

  logic             w_st_vld   [LATENCY];
  logic             w_st_carry [LATENCY];
  logic [WIDTH-1:0] w_st_val   [LATENCY];
  logic [SAW-1:0]   w_st_amt   [LATENCY];
  logic [CW-1:0]    w_st_ctl   [LATENCY];
  logic [WIDTH-1:0] w_last_shf;

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    logic             w_vld_in;
    logic             w_carry_in;
    logic [WIDTH-1:0] w_val_in;
    logic [SAW-1:0]   w_amt_in;
    logic [CW-1:0]    w_ctl_in;
    logic [WIDTH-1:0] w_shf;
    logic             r_vld;
    logic             r_carry;
    logic [WIDTH-1:0] r_val;
    logic [SAW-1:0]   r_amt;
    logic [CW-1:0]    r_ctl;

    if (s == 0) begin : g_head
      assign w_vld_in   = w_acc;
      assign w_carry_in = w_dec_carry;
      assign w_val_in   = w_dec_val;
      assign w_amt_in   = w_dec_amt;
      assign w_ctl_in   = w_dec_ctl;
    end else begin : g_body
      assign w_vld_in   = w_st_vld[s-1];
      assign w_carry_in = w_st_carry[s-1];
      assign w_val_in   = w_st_val[s-1];
      assign w_amt_in   = w_st_amt[s-1];
      assign w_ctl_in   = w_st_ctl[s-1];
    end

    always_comb begin
      w_shf = w_val_in;
      for (int k = 0; k < SAW; k++) begin
        if (stage_of(k) == s && w_amt_in[SAW-1-k])
          w_shf = shift_lvl(w_shf, 1 << (SAW - 1 - k), w_ctl_in);
      end
    end

    // One global advance: a stall freezes every stage, bubbles included.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_vld   <= 1'b0;
        r_carry <= 1'b0;
        r_val   <= '0;
        r_amt   <= '0;
        r_ctl   <= '0;
      end else if (w_adv) begin
        r_vld   <= w_vld_in;
        r_carry <= w_carry_in;
        r_val   <= w_shf;
        r_amt   <= w_amt_in;
        r_ctl   <= w_ctl_in;
      end
    end

    assign w_st_vld[s]   = r_vld;
    assign w_st_carry[s] = r_carry;
    assign w_st_val[s]   = r_val;
    assign w_st_amt[s]   = r_amt;
    assign w_st_ctl[s]   = r_ctl;

    if (s == LATENCY - 1) begin : g_tail
      assign w_last_shf = w_shf;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdy_en <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_adv) r_zero <= (w_last_shf == '0);
    end
  end

  assign out_valid = w_st_vld[LATENCY-1];
  assign result    = w_st_val[LATENCY-1];
  assign carry     = w_st_carry[LATENCY-1];
  assign zero      = r_zero;

endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe: directed cases, backpressure, reset flush and random ops vs a reference model.
module tb_shifter_pipe;
  localparam int W   = 16;
  localparam int L   = 2;
  localparam int SAW = $clog2(W);

  logic           clk;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic [W-1:0]   src_a;
  logic [W-1:0]   src_b;
  logic [SAW-1:0] shamt;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic           carry;
  logic           zero;

  shifter_pipe #(.WIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int n_out        = 0;
  int bp_mode      = 0;
  bit chk_rdy      = 0;
  logic [W+1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: {zero, carry, result}
  function automatic logic [W+1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [SAW-1:0] sh);
    logic [W-1:0] r;
    logic         c;
    int           n;
    longint       sa;
    r = a;
    c = 1'b0;
    n = int'(sh);
    case (o)
      3'd0: if (n > 0) begin r = a << n; c = a[W-n]; end
      3'd1: if (n > 0) begin r = a >> n; c = a[n-1]; end
      3'd2: if (n > 0) begin
        sa = longint'(a);
        if (a[W-1]) sa = sa - (longint'(1) << W);
        r = W'(sa >>> n);
        c = a[n-1];
      end
      3'd3: r = b << (W / 2);
      3'd4: begin
        n = int'(b[SAW:0]);
        if (n >= (1 << SAW)) n = n - (1 << (SAW + 1));
        if (n > 0) begin
          r = a << n; c = a[W-n];
        end else if (n < 0) begin
          n = -n;
          if (n > W - 1) n = W - 1;
          r = a >> n; c = a[n-1];
        end
      end
`ifdef SHIFTER_PIPE_ROTATE_EN
      3'd5: if (n > 0) begin r = (a << n) | (a >> (W - n)); c = r[0]; end
      3'd6: if (n > 0) begin r = (a >> n) | (a << (W - n)); c = r[W-1]; end
`endif
      default: ;
    endcase
    return {(r == '0), c, r};
  endfunction

  // driver: offer one op, push its expectation when it is accepted
  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [SAW-1:0] s, input logic [W+1:0] e);
    bit done;
    done = 0;
    @(negedge clk);
    op = o; src_a = a; src_b = b; shamt = s; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1;
        @(posedge clk);
        #1 in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      in_valid = 1'b0;
      check("accept_timeout", 0, 1);
    end
  endtask

  task automatic send_rand();
    logic [2:0]     o;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [SAW-1:0] s;
    o = 3'($urandom_range(0, 7));
    a = W'($urandom);
    b = W'($urandom);
    if ($urandom_range(0, 3) == 0) b[SAW:0] = (SAW+1)'(1 << SAW);
    s = SAW'($urandom_range(0, W - 1));
    send(o, a, b, s, model(o, a, b, s));
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // consumer side: out_ready pattern
  initial begin
    int idx;
    logic [3:0] pat;
    idx = 0;
    pat = 4'b1001;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (bp_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[idx]; idx = (idx + 1) % 4; end
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        check("reset_out_valid", out_valid, 0);
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("result", {zero, carry, result}, e);
          end
        end
        if (chk_rdy) check("in_ready", in_ready, (!out_valid) || out_ready);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_before;
    reset_n = 1'b0; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0; shamt = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 16'h0000);
    check("rst_carry", carry, 0);
    check("rst_zero", zero, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst", in_ready, 1);
    chk_rdy = 1;

    // first op: latency from accept
    send(3'd0, 16'h0001, 16'h0000, 4'd4, {1'b0, 1'b0, 16'h0010});
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = i;
    end
    check("latency", lat, L);

    // directed cases
    send(3'd2, 16'h8001, 16'h0000, 4'd1, {1'b0, 1'b1, 16'hC000});
    send(3'd1, 16'h8001, 16'h0000, 4'd1, {1'b0, 1'b1, 16'h4000});
    send(3'd3, 16'h1234, 16'h00AB, 4'd7, {1'b0, 1'b0, 16'hAB00});
    send(3'd4, 16'hF000, 16'hFFFC, 4'd0, {1'b0, 1'b0, 16'h0F00});
    send(3'd4, 16'hF000, 16'h0003, 4'd0, {1'b0, 1'b1, 16'h8000});
    send(3'd1, 16'h0001, 16'h0000, 4'd1, {1'b1, 1'b1, 16'h0000});
    send(3'd4, 16'hC000, 16'h0010, 4'd0, {1'b0, 1'b1, 16'h0001});
    send(3'd4, 16'h8000, 16'hFFF0, 4'd0, {1'b0, 1'b0, 16'h0001});
    send(3'd0, 16'h1234, 16'h0000, 4'd0, {1'b0, 1'b0, 16'h1234});
    send(3'd7, 16'hABCD, 16'h5555, 4'd3, {1'b0, 1'b0, 16'hABCD});
`ifdef SHIFTER_PIPE_ROTATE_EN
    send(3'd5, 16'h8001, 16'h0000, 4'd1, {1'b0, 1'b1, 16'h0003});
    send(3'd6, 16'h0001, 16'h0000, 4'd1, {1'b0, 1'b1, 16'h8000});
`else
    send(3'd5, 16'h8001, 16'h0000, 4'd1, {1'b0, 1'b0, 16'h8001});
    send(3'd6, 16'h0001, 16'h0000, 4'd1, {1'b0, 1'b0, 16'h0001});
`endif
    drain();

    // backpressure stream
    n_before = n_out;
    bp_mode = 1;
    repeat (6) send_rand();
    drain();
    bp_mode = 0;
    check("bp_count", n_out - n_before, 6);

    // reset with two ops in flight
    send_rand();
    send_rand();
    reset_n = 1'b0;
    #1;
    check("rst_flight_valid", out_valid, 0);
    chk_rdy = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rdy_after_rst2", in_ready, 1);
    chk_rdy = 1;
    n_before = n_out;
    repeat (10) @(negedge clk);
    check("stale_none", n_out - n_before, 0);

    // random traffic with random backpressure
    bp_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send_rand();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    bp_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
